alu_seq: RTL

- Command sequencer that initiates operations on the team's 16-bit combinational ALU.
- The ALU is the responder: op 00 ADD, 01 SUB (i0 + ~i1 + 1), 10 AND, 11 OR, with carry-out.
- Accepts commands over a valid/ready channel, drives the ALU's op/i0/i1, captures o/cout and returns them over a valid/ready response channel.
- Adds a multi-cycle MUL command built from iterated ALU ADDs (shift-add).

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul_dp.sv | 64 ++++++
 rtl/alu_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: command ops, ALU ops, FSM states.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_mul_dp.sv
// Shift-add multiply datapath: accumulator, shifted multiplicand/multiplier, overflow tracking.
// ALU_SEQ_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
import alu_seq_pkg::*;

module alu_seq_mul_dp #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] alu_o_i,
    input  logic             alu_cout_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] addend_o,
    output logic             ovf_next_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q, mcand_ovf_q;

    assign acc_o      = acc_q;
    assign addend_o   = mplier_q[0] ? mcand_q : '0;
    // A used partial product that lost bits off the top already exceeds the result width.
    assign ovf_next_o = ovf_q | alu_cout_i | (mplier_q[0] & mcand_ovf_q);

`ifdef ALU_SEQ_EARLY_EXIT_EN
    assign done_o = (cnt_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign done_o = (cnt_q == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mcand_ovf_q <= 1'b0;
        end else if (start_i) begin
            acc_q       <= '0;
            mcand_q     <= a_i;
            mplier_q    <= b_i;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mcand_ovf_q <= 1'b0;
        end else if (step_i) begin
            acc_q       <= alu_o_i;
            mcand_q     <= mcand_q << 1;
            mplier_q    <= mplier_q >> 1;
            cnt_q       <= cnt_q + CW'(1);
            ovf_q       <= ovf_next_o;
            mcand_ovf_q <= mcand_ovf_q | mcand_q[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Command sequencer driving the 16-bit combinational ALU, with an iterated shift-add MUL.
// ALU_SEQ_EARLY_EXIT_EN: MUL stops once no multiplier bits remain (see alu_seq_mul_dp).
import alu_seq_pkg::*;

module alu_seq #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    output logic [1:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_i0_o,
    output logic [WIDTH-1:0] alu_i1_o,
    input  logic [WIDTH-1:0] alu_o_i,
    input  logic             alu_cout_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_cout_o,
    output logic             rsp_err_o
);

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_cout_q, rsp_err_q;

    logic             cmd_hs;
    logic             mul_start;
    logic [WIDTH-1:0] mul_acc, mul_addend;
    logic             mul_ovf_next, mul_done;

    assign cmd_hs    = (state_q == IDLE) && cmd_valid_i;
    assign mul_start = cmd_hs && (cmd_op_i == OP_MUL);

    alu_seq_mul_dp #(.WIDTH(WIDTH)) u_mul_dp (
        .clk_i      (clk_i),
        .rst_i      (reset_i),
        .start_i    (mul_start),
        .step_i     (state_q == MUL),
        .a_i        (cmd_a_i),
        .b_i        (cmd_b_i),
        .alu_o_i    (alu_o_i),
        .alu_cout_i (alu_cout_i),
        .acc_o      (mul_acc),
        .addend_o   (mul_addend),
        .ovf_next_o (mul_ovf_next),
        .done_o     (mul_done)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                if (cmd_op_i <= OP_OR)        state_d = EXEC;
                else if (cmd_op_i == OP_MUL)  state_d = MUL;
                else                          state_d = RESP;
            end
            EXEC: state_d = RESP;
            MUL:  if (mul_done) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        alu_op_o    = ALU_ADD;
        alu_i0_o    = '0;
        alu_i1_o    = '0;
        unique case (state_q)
            IDLE: cmd_ready_o = 1'b1;
            EXEC: begin
                alu_op_o = op_q;
                alu_i0_o = a_q;
                alu_i1_o = b_q;
            end
            MUL: begin
                alu_op_o = ALU_ADD;
                alu_i0_o = mul_acc;
                alu_i1_o = mul_addend;
            end
            RESP: rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                op_q <= cmd_op_i[1:0];
                a_q  <= cmd_a_i;
                b_q  <= cmd_b_i;
                if (cmd_op_i > OP_MUL) begin
                    rsp_data_q <= '0;
                    rsp_cout_q <= 1'b0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    rsp_err_q  <= 1'b0;
                end
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_o_i;
                rsp_cout_q <= (op_q == ALU_AND || op_q == ALU_OR) ? 1'b0 : alu_cout_i;
            end
            if (state_q == MUL && mul_done) begin
                rsp_data_q <= alu_o_i;
                rsp_cout_q <= mul_ovf_next;
            end
        end
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_cout_o = rsp_cout_q;
    assign rsp_err_o  = rsp_err_q;

endmodule
